plic_gateway: RTL and testbench

//  Per-source interrupt gateway sitting directly upstream of the 8-input PLIC priority/arbiter stage.

---
 rtl/plic_pkg.sv | 13 +
 rtl/plic_gateway_if.sv | 25 ++
 rtl/plic_gw_src.sv | 74 +++++++
 rtl/plic_gateway.sv | 54 +++++
 tb/tb_plic_gateway.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/plic_pkg.sv
// Shared constants and state encoding for the PLIC interrupt gateway.
package plic_pkg;
  localparam int N_SRC       = 8;
  localparam int ID_W        = 3;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLAIMED = 2'd2
  } gw_state_e;
endpackage

// File: rtl/plic_gateway_if.sv
// Interrupt lines, claim/complete handshake and status outputs between core side and gateway.
interface plic_gateway_if;
  import plic_pkg::*;

  logic [N_SRC-1:0] i_irq_src;
  logic [N_SRC-1:0] i_trig_mode;
  logic             i_claim_vld;
  logic [ID_W-1:0]  i_claim_id;
  logic             i_cmpl_vld;
  logic [ID_W-1:0]  i_cmpl_id;
  logic [N_SRC-1:0] o_interrupt;
  logic [N_SRC-1:0] o_in_service;
  logic             o_claim_err;
  logic             o_cmpl_err;

  modport master (
    output i_irq_src, i_trig_mode, i_claim_vld, i_claim_id, i_cmpl_vld, i_cmpl_id,
    input  o_interrupt, o_in_service, o_claim_err, o_cmpl_err
  );

  modport slave (
    input  i_irq_src, i_trig_mode, i_claim_vld, i_claim_id, i_cmpl_vld, i_cmpl_id,
    output o_interrupt, o_in_service, o_claim_err, o_cmpl_err
  );
endinterface

// File: rtl/plic_gw_src.sv
// One gateway source: synchroniser, rising-edge detect, edge counter and request FSM.
// state   | meaning
// IDLE    | no request held; evaluates level line or edge count each cycle
// PENDING | request presented to the arbiter, waiting for a claim
// CLAIMED | core is servicing this source; blocked until complete
module plic_gw_src
  import plic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic irq,
  input  logic trig_mode,
  input  logic claim_hit,
  input  logic cmpl_hit,
  output logic pend,
  output logic in_svc,
  output logic claim_ok,
  output logic cmpl_ok
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt_q;
  gw_state_e              state_q, state_d;
  logic                   sync_out;
  logic                   edge_det;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign edge_det = sync_out & ~prev_q;
  assign claim_ok = claim_hit && (state_q == PENDING);
  assign cmpl_ok  = cmpl_hit && (state_q == CLAIMED);
  assign pend     = (state_q == PENDING);
  assign in_svc   = (state_q == CLAIMED);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
      prev_q <= sync_out;
    end
  end

  // Edge and accepted claim together cancel; level mode pins the count at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (!trig_mode) begin
      cnt_q <= '0;
    end else if (edge_det && !claim_ok) begin
      if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end else if (claim_ok && !edge_det) begin
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trig_mode ? (cnt_q != '0) : sync_out) state_d = PENDING;
      PENDING: if (claim_ok) state_d = CLAIMED;
      CLAIMED: if (cmpl_ok)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/plic_gateway.sv
// Gateway top: per-source instances, claim/complete id decode, registered error pulses.
module plic_gateway
  import plic_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst_n,
  plic_gateway_if.slave  bus
);
  logic [N_SRC-1:0] claim_hit, cmpl_hit;
  logic [N_SRC-1:0] claim_ok, cmpl_ok;
  logic [N_SRC-1:0] pend, in_svc;
  logic             claim_err_q, cmpl_err_q;

  // Out-of-range ids hit nothing and therefore fall through to the error path.
  always_comb begin
    claim_hit = '0;
    cmpl_hit  = '0;
    if (bus.i_claim_vld && (32'(bus.i_claim_id) < N_SRC)) claim_hit[bus.i_claim_id] = 1'b1;
    if (bus.i_cmpl_vld && (32'(bus.i_cmpl_id) < N_SRC))   cmpl_hit[bus.i_cmpl_id]   = 1'b1;
  end

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    plic_gw_src #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_src (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .irq      (bus.i_irq_src[k]),
      .trig_mode(bus.i_trig_mode[k]),
      .claim_hit(claim_hit[k]),
      .cmpl_hit (cmpl_hit[k]),
      .pend     (pend[k]),
      .in_svc   (in_svc[k]),
      .claim_ok (claim_ok[k]),
      .cmpl_ok  (cmpl_ok[k])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      claim_err_q <= 1'b0;
      cmpl_err_q  <= 1'b0;
    end else begin
      claim_err_q <= bus.i_claim_vld && !(|claim_ok);
      cmpl_err_q  <= bus.i_cmpl_vld && !(|cmpl_ok);
    end
  end

  assign bus.o_interrupt  = pend;
  assign bus.o_in_service = in_svc;
  assign bus.o_claim_err  = claim_err_q;
  assign bus.o_cmpl_err   = cmpl_err_q;
endmodule

// File: tb/tb_plic_gateway.sv
// Directed self-checking bench for plic_gateway; inputs driven and outputs sampled on the falling edge.
module tb_plic_gateway;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  plic_gateway_if bus ();

  plic_gateway dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_claim(input logic [2:0] id);
    bus.i_claim_vld = 1'b1;
    bus.i_claim_id  = id;
    tick();
    bus.i_claim_vld = 1'b0;
  endtask

  task automatic do_cmpl(input logic [2:0] id);
    bus.i_cmpl_vld = 1'b1;
    bus.i_cmpl_id  = id;
    tick();
    bus.i_cmpl_vld = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.o_interrupt !== 8'h00) begin errors++; $display("FAIL rst_int: got %h exp 00", bus.o_interrupt); end
    checks++; if (bus.o_in_service !== 8'h00) begin errors++; $display("FAIL rst_svc: got %h exp 00", bus.o_in_service); end
    checks++; if (bus.o_claim_err !== 1'b0) begin errors++; $display("FAIL rst_cerr: got %b exp 0", bus.o_claim_err); end
    checks++; if (bus.o_cmpl_err !== 1'b0) begin errors++; $display("FAIL rst_perr: got %b exp 0", bus.o_cmpl_err); end
  endtask

  task automatic test_level();
    bus.i_trig_mode[2] = 1'b0;
    bus.i_irq_src[2] = 1'b1;
    tick(2);
    checks++; if (bus.o_interrupt !== 8'h00) begin errors++; $display("FAIL lvl_early: got %h exp 00", bus.o_interrupt); end
    tick();
    checks++; if (bus.o_interrupt !== 8'h04) begin errors++; $display("FAIL lvl_pend: got %h exp 04", bus.o_interrupt); end
    do_claim(3'd2);
    checks++; if (bus.o_interrupt !== 8'h00) begin errors++; $display("FAIL lvl_claim_int: got %h exp 00", bus.o_interrupt); end
    checks++; if (bus.o_in_service !== 8'h04) begin errors++; $display("FAIL lvl_claim_svc: got %h exp 04", bus.o_in_service); end
    checks++; if (bus.o_claim_err !== 1'b0) begin errors++; $display("FAIL lvl_claim_err: got %b exp 0", bus.o_claim_err); end
    do_cmpl(3'd2);
    checks++; if (bus.o_interrupt !== 8'h00 || bus.o_in_service !== 8'h00) begin errors++; $display("FAIL lvl_idle: got int %h svc %h exp 00 00", bus.o_interrupt, bus.o_in_service); end
    tick();
    checks++; if (bus.o_interrupt !== 8'h04) begin errors++; $display("FAIL lvl_repend: got %h exp 04", bus.o_interrupt); end
    bus.i_irq_src[2] = 1'b0;
    tick(4);
    checks++; if (bus.o_interrupt !== 8'h04) begin errors++; $display("FAIL lvl_latched: got %h exp 04", bus.o_interrupt); end
    do_claim(3'd2);
    do_cmpl(3'd2);
    tick(3);
    checks++; if (bus.o_interrupt !== 8'h00) begin errors++; $display("FAIL lvl_quiet: got %h exp 00", bus.o_interrupt); end
  endtask

  task automatic test_edge();
    bus.i_trig_mode[5] = 1'b1;
    tick();
    for (int p = 0; p < 3; p++) begin
      bus.i_irq_src[5] = 1'b1; tick();
      bus.i_irq_src[5] = 1'b0; tick(2);
    end
    tick(4);
    for (int r = 0; r < 3; r++) begin
      checks++; if (bus.o_interrupt !== 8'h20) begin errors++; $display("FAIL edge_pend_r%0d: got %h exp 20", r, bus.o_interrupt); end
      do_claim(3'd5);
      checks++; if (bus.o_in_service !== 8'h20) begin errors++; $display("FAIL edge_svc_r%0d: got %h exp 20", r, bus.o_in_service); end
      do_cmpl(3'd5);
      tick();
    end
    tick(3);
    checks++; if (bus.o_interrupt !== 8'h00) begin errors++; $display("FAIL edge_drained: got %h exp 00", bus.o_interrupt); end
    bus.i_trig_mode[5] = 1'b0;
  endtask

  task automatic test_saturation();
    int rounds_ok = 0;
    bus.i_trig_mode[0] = 1'b1;
    tick();
    for (int p = 0; p < 20; p++) begin
      bus.i_irq_src[0] = 1'b1; tick();
      bus.i_irq_src[0] = 1'b0; tick();
    end
    tick(4);
    for (int r = 0; r < 15; r++) begin
      if (bus.o_interrupt[0] === 1'b1) begin
        do_claim(3'd0);
        if (bus.o_claim_err === 1'b0 && bus.o_in_service[0] === 1'b1) rounds_ok++;
        do_cmpl(3'd0);
        tick();
      end
    end
    checks++; if (rounds_ok !== 15) begin errors++; $display("FAIL sat_rounds: got %0d exp 15", rounds_ok); end
    tick(2);
    checks++; if (bus.o_interrupt[0] !== 1'b0) begin errors++; $display("FAIL sat_empty: got %b exp 0", bus.o_interrupt[0]); end
    do_claim(3'd0);
    checks++; if (bus.o_claim_err !== 1'b1) begin errors++; $display("FAIL sat_extra_claim: got %b exp 1", bus.o_claim_err); end
    bus.i_trig_mode[0] = 1'b0;
    tick();
  endtask

  task automatic test_errors();
    do_claim(3'd1);
    checks++; if (bus.o_claim_err !== 1'b1) begin errors++; $display("FAIL err_claim_idle: got %b exp 1", bus.o_claim_err); end
    checks++; if (bus.o_interrupt[1] !== 1'b0 || bus.o_in_service[1] !== 1'b0) begin errors++; $display("FAIL err_claim_state: got int %b svc %b exp 0 0", bus.o_interrupt[1], bus.o_in_service[1]); end
    tick();
    checks++; if (bus.o_claim_err !== 1'b0) begin errors++; $display("FAIL err_claim_pulse: got %b exp 0", bus.o_claim_err); end
    bus.i_irq_src[1] = 1'b1;
    tick(4);
    do_cmpl(3'd1);
    checks++; if (bus.o_cmpl_err !== 1'b1) begin errors++; $display("FAIL err_cmpl_pend: got %b exp 1", bus.o_cmpl_err); end
    checks++; if (bus.o_interrupt !== 8'h02 || bus.o_in_service !== 8'h00) begin errors++; $display("FAIL err_cmpl_state: got int %h svc %h exp 02 00", bus.o_interrupt, bus.o_in_service); end
    tick();
    checks++; if (bus.o_cmpl_err !== 1'b0) begin errors++; $display("FAIL err_cmpl_pulse: got %b exp 0", bus.o_cmpl_err); end
    bus.i_irq_src[1] = 1'b0;
    do_claim(3'd1);
    do_cmpl(3'd1);
    tick(3);
  endtask

  task automatic test_same_cycle();
    bus.i_irq_src[6] = 1'b1;
    tick(4);
    do_claim(3'd6);
    bus.i_irq_src[6] = 1'b0;
    bus.i_irq_src[3] = 1'b1;
    tick(4);
    checks++; if (bus.o_interrupt !== 8'h08 || bus.o_in_service !== 8'h40) begin errors++; $display("FAIL same_setup: got int %h svc %h exp 08 40", bus.o_interrupt, bus.o_in_service); end
    bus.i_irq_src[3] = 1'b0;
    bus.i_claim_vld = 1'b1; bus.i_claim_id = 3'd3;
    bus.i_cmpl_vld  = 1'b1; bus.i_cmpl_id  = 3'd6;
    tick();
    bus.i_claim_vld = 1'b0; bus.i_cmpl_vld = 1'b0;
    checks++; if (bus.o_in_service !== 8'h08) begin errors++; $display("FAIL same_diff_svc: got %h exp 08", bus.o_in_service); end
    checks++; if (bus.o_claim_err !== 1'b0 || bus.o_cmpl_err !== 1'b0) begin errors++; $display("FAIL same_diff_err: got claim %b cmpl %b exp 0 0", bus.o_claim_err, bus.o_cmpl_err); end
    tick(3);
    bus.i_claim_vld = 1'b1; bus.i_claim_id = 3'd3;
    bus.i_cmpl_vld  = 1'b1; bus.i_cmpl_id  = 3'd3;
    tick();
    bus.i_claim_vld = 1'b0; bus.i_cmpl_vld = 1'b0;
    checks++; if (bus.o_claim_err !== 1'b1 || bus.o_cmpl_err !== 1'b0) begin errors++; $display("FAIL same_id_err: got claim %b cmpl %b exp 1 0", bus.o_claim_err, bus.o_cmpl_err); end
    checks++; if (bus.o_in_service !== 8'h00) begin errors++; $display("FAIL same_id_svc: got %h exp 00", bus.o_in_service); end
    tick(3);
    checks++; if (bus.o_interrupt !== 8'h00) begin errors++; $display("FAIL same_quiet: got %h exp 00", bus.o_interrupt); end
  endtask

  task automatic test_reset_mid();
    bus.i_irq_src[4] = 1'b1;
    bus.i_trig_mode[1] = 1'b1;
    tick(4);
    do_claim(3'd4);
    for (int p = 0; p < 2; p++) begin
      bus.i_irq_src[1] = 1'b1; tick();
      bus.i_irq_src[1] = 1'b0; tick();
    end
    tick(3);
    checks++; if (bus.o_interrupt !== 8'h02 || bus.o_in_service !== 8'h10) begin errors++; $display("FAIL rstm_setup: got int %h svc %h exp 02 10", bus.o_interrupt, bus.o_in_service); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_interrupt !== 8'h00 || bus.o_in_service !== 8'h00) begin errors++; $display("FAIL rstm_async: got int %h svc %h exp 00 00", bus.o_interrupt, bus.o_in_service); end
    bus.i_irq_src = '0;
    tick(3);
    rst_n = 1'b1;
    tick(8);
    checks++; if (bus.o_interrupt !== 8'h00) begin errors++; $display("FAIL rstm_int: got %h exp 00", bus.o_interrupt); end
    checks++; if (bus.o_in_service !== 8'h00) begin errors++; $display("FAIL rstm_svc: got %h exp 00", bus.o_in_service); end
    bus.i_trig_mode[1] = 1'b0;
  endtask

  initial begin
    bus.i_irq_src   = '0;
    bus.i_trig_mode = '0;
    bus.i_claim_vld = 1'b0;
    bus.i_claim_id  = '0;
    bus.i_cmpl_vld  = 1'b0;
    bus.i_cmpl_id   = '0;
    tick(3);
    test_reset();
    rst_n = 1'b1;
    tick(2);
    test_level();
    test_edge();
    test_saturation();
    test_errors();
    test_same_cycle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
